// File: rtl/uart_frame_decoder.sv
// Parses UART Rx bytes framed as SOF, LEN, CMD, payload, EOF and drives the
// matrix-vector engine's dimension, start/resend controls and load strobes.
module uart_frame_decoder #(
  parameter logic [7:0] SOF     = 8'hFE,
  parameter logic [7:0] EOF     = 8'hEF,
  parameter int         N_MAX   = 15,
  parameter int         TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_flag,
  input  logic [7:0] Rx_data,
  output logic       push_mat,
  output logic       push_vec,
  output logic [7:0] push_data,
  output logic [4:0] N_out,
  output logic       start_pulse,
  output logic       resend_pulse,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_CMD     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_EOFW    = 3'd4;

  localparam logic [7:0] C_SETN   = 8'h01;
  localparam logic [7:0] C_RESEND = 8'h02;
  localparam logic [7:0] C_START  = 8'h03;
  localparam logic [7:0] C_LOAD   = 8'h04;

  localparam logic [7:0]  N_MAX_B = 8'(N_MAX);
  localparam bit          TO_EN   = (TIMEOUT > 0);
  localparam logic [10:0] TO_LAST = (TIMEOUT > 0) ? 11'(TIMEOUT - 1) : 11'd0;

  logic [2:0]  r_state;
  logic        r_flagPrev;
  logic [7:0]  r_count;
  logic [7:0]  r_cmd;
  logic        r_toVec;
  logic [4:0]  r_shadowN;
  logic [10:0] r_timer;

  logic        w_accept;
  logic [7:0]  w_nSq;
  logic [7:0]  w_payLen;
  logic        w_timeout;

  assign w_accept  = Rx_flag & ~r_flagPrev;
  assign w_nSq     = {3'b000, N_out} * {3'b000, N_out};
  assign w_payLen  = r_count - 8'd2;
  // Timer holds the number of idle cycles since the last accepted byte.
  assign w_timeout = TO_EN && (r_state != S_IDLE) && !w_accept && (r_timer == TO_LAST);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_flagPrev   <= 1'b0;
      r_count      <= 8'd0;
      r_cmd        <= 8'd0;
      r_toVec      <= 1'b0;
      r_shadowN    <= 5'd0;
      r_timer      <= 11'd0;
      push_mat     <= 1'b0;
      push_vec     <= 1'b0;
      push_data    <= 8'd0;
      N_out        <= 5'd0;
      start_pulse  <= 1'b0;
      resend_pulse <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_flagPrev   <= Rx_flag;
      push_mat     <= 1'b0;
      push_vec     <= 1'b0;
      start_pulse  <= 1'b0;
      resend_pulse <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;

      if (r_state == S_IDLE || w_accept) begin
        r_timer <= 11'd0;
      end else if (r_timer != 11'h7FF) begin
        r_timer <= r_timer + 11'd1;
      end

      if (w_timeout) begin
        frame_err <= 1'b1;
        r_state   <= S_IDLE;
      end else if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (Rx_data == SOF) r_state <= S_LEN;
          end
          S_LEN: begin
            if (Rx_data < 8'd2) begin
              frame_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_count <= Rx_data;
              r_state <= S_CMD;
            end
          end
          S_CMD: begin
            r_cmd   <= Rx_data;
            r_count <= r_count - 8'd1;
            case (Rx_data)
              C_SETN: begin
                if (r_count == 8'd3) r_state <= S_PAYLOAD;
                else begin
                  frame_err <= 1'b1;
                  r_state   <= S_IDLE;
                end
              end
              C_RESEND, C_START: begin
                if (r_count == 8'd2) r_state <= S_EOFW;
                else begin
                  frame_err <= 1'b1;
                  r_state   <= S_IDLE;
                end
              end
              C_LOAD: begin
                // Matrix length takes priority if N*N and N ever coincide.
                if (N_out != 5'd0 && w_payLen == w_nSq) begin
                  r_toVec <= 1'b0;
                  r_state <= S_PAYLOAD;
                end else if (N_out != 5'd0 && w_payLen == {3'b000, N_out}) begin
                  r_toVec <= 1'b1;
                  r_state <= S_PAYLOAD;
                end else begin
                  frame_err <= 1'b1;
                  r_state   <= S_IDLE;
                end
              end
              default: begin
                frame_err <= 1'b1;
                r_state   <= S_IDLE;
              end
            endcase
          end
          S_PAYLOAD: begin
            r_count <= r_count - 8'd1;
            if (r_count == 8'd2) r_state <= S_EOFW;
            if (r_cmd == C_SETN) begin
              if (Rx_data < 8'd2 || Rx_data > N_MAX_B) begin
                frame_err <= 1'b1;
                r_state   <= S_IDLE;
              end else begin
                r_shadowN <= Rx_data[4:0];
              end
            end else begin
              push_data <= Rx_data;
              push_vec  <= r_toVec;
              push_mat  <= ~r_toVec;
            end
          end
          S_EOFW: begin
            r_state <= S_IDLE;
            if (Rx_data == EOF) begin
              frame_ok <= 1'b1;
              case (r_cmd)
                C_SETN:   N_out        <= r_shadowN;
                C_START:  start_pulse  <= 1'b1;
                C_RESEND: resend_pulse <= 1'b1;
                default:  ;
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Upstream stage of the matrix-vector engine: parses UART receive bytes framed as SOF, LEN, CMD, payload, EOF.
- Drives the engine's configuration (N), its start/resend controls, and its matrix/vector load strobes.
- Sits between the UART Rx byte interface (byte plus strobe flag) and the multiply core.

Parameters:
- SOF, 8'hFE, start-of-frame byte
- EOF, 8'hEF, end-of-frame byte
- N_MAX, 15, largest accepted dimension; keeps N*N+2 <= 255
- TIMEOUT, 1000, idle clk cycles allowed between bytes inside a frame; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- Rx_flag  in  1  UART byte-ready flag; level, may stay high for several cycles
- Rx_data  in  8  received byte, valid while Rx_flag is high
- push_mat  out  1  one-cycle strobe: push_data is a matrix element
- push_vec  out  1  one-cycle strobe: push_data is a vector element
- push_data  out  8  payload byte
- N_out  out  5  configured dimension; 0 means unconfigured
- start_pulse  out  1  one-cycle strobe: start the multiply
- resend_pulse  out  1  one-cycle strobe: retransmit the last result
- frame_ok  out  1  one-cycle strobe: frame accepted
- frame_err  out  1  one-cycle strobe: frame rejected; downstream discards partial loads
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst=0): state IDLE, all outputs 0, N_out=0, counters cleared, Rx_flag history register cleared.
- Byte acceptance: a byte is accepted only on a rising edge of Rx_flag (Rx_flag=1 and the registered previous value=0). Rx_data is sampled in that same cycle.
- Latency: every output is registered and appears exactly 1 cycle after the accepting edge cycle. Strobes last 1 cycle.
- LEN counts the bytes after LEN, up to and including EOF, so LEN = 1 (CMD) + payload + 1 (EOF).
- Commands:
  - 0x01 SET_N: payload 1 byte, LEN=3. Value must be 2..N_MAX.
  - 0x02 RESEND: no payload, LEN=2.
  - 0x03 START: no payload, LEN=2.
  - 0x04 LOAD: if LEN-2 == N*N, payload goes to push_mat; else if LEN-2 == N, payload goes to push_vec; otherwise error. LOAD with N_out=0 is an error.
- FSM:
  - IDLE: a SOF byte moves to LEN. Any other byte is discarded silently, with no error.
  - LEN: LEN < 2 gives an error. Otherwise store the remaining count and move to CMD.
  - CMD: validate the command against LEN as listed above; an invalid pair gives an error. If payload remains, move to PAYLOAD; else move to EOFW.
  - PAYLOAD: each byte decrements the count. LOAD bytes produce push_mat or push_vec together with push_data. The SET_N byte is held in a shadow register. When the count reaches 1, move to EOFW.
  - EOFW: a byte equal to EOF commits the frame:
    - SET_N updates N_out;
    - START raises start_pulse;
    - RESEND raises resend_pulse;
    - frame_ok is raised for all commands.
    Any other byte gives an error. Both cases return to IDLE.
- Error handling: frame_err pulses once, state returns to IDLE, N_out is unchanged. Push strobes already issued are not retracted.
- Data bytes are never resynchronised: a 0xFE byte inside PAYLOAD is treated as data.
- Timeout: an 11-bit counter runs in any non-IDLE state and clears on each accepted byte. When it reaches TIMEOUT, frame_err pulses and the FSM returns to IDLE.
- Multiple Rx_flag edges: only one byte is accepted per rising edge, regardless of how long the flag stays high.
- Reset during a frame: the FSM goes to IDLE immediately, no pulses are emitted, and N_out returns to 0.
- Width rules: N*N is computed in 8 bits (max 225). LEN is compared in 8 bits.

Test Plan:
- Bytes FE 03 01 04 EF, each Rx_flag held 5 cycles -> N_out=4 one cycle after the EF edge; frame_ok pulses once; no push strobes; one byte accepted per edge.
- With N=4: FE 12 04 00..0F EF -> 16 push_mat strobes with push_data 00..0F in order; frame_ok pulses; push_vec never asserts.
- With N=4: FE 06 04 01 02 03 04 EF, then FE 02 03 EF -> 4 push_vec strobes (01..04); then start_pulse and frame_ok pulse together one cycle after the EF edge.
- FE 03 01 04 AA -> frame_err pulse, N_out stays at its prior value (0 after reset); FE 03 01 10 EF (N=16) -> frame_err; LOAD with N_out=0 -> frame_err at the CMD byte.
- With TIMEOUT=20: FE 02 03, then no bytes -> frame_err 20 cycles after the last edge; busy=0 afterwards; the next FE 02 02 EF gives resend_pulse.
- rst driven low while in PAYLOAD -> all outputs 0 and N_out=0 at once; the following stray bytes 04 EF -> no output activity.
